// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the regfile_sb register file: write, clear, reserve and read ports.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) ();
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rd_stall;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;

    modport master (
        output clr_en, clr_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_stall, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b
    );

    modport slave (
        input  clr_en, clr_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_stall, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with one write port, two registered read ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to make reads see same-cycle writes and clears.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input logic          clk,
    input logic          rstAll,
    regfile_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [ADDR_W-1:0] rd_addr   [2];
    logic [DATA_W-1:0] rd_data_d [2];
    logic [DATA_W-1:0] rd_data_q [2];
    logic [1:0]        rd_busy_d;
    logic [1:0]        rd_busy_q;

    assign rd_addr[0] = bus.rd_addr_a;
    assign rd_addr[1] = bus.rd_addr_b;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = mem_q[i];
            busy_d[i] = busy_q[i];
            if (bus.clr_en && bus.clr_addr == ADDR_W'(i)) begin
                mem_d[i]  = '0;
                busy_d[i] = 1'b0;
            end else begin
                if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    mem_d[i] = bus.wr_data;
                end
                // A reserve alongside a write keeps the bit set: the newer producer wins.
                if (bus.rsv_en && bus.rsv_addr == ADDR_W'(i)) begin
                    busy_d[i] = 1'b1;
                end else if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (ZERO_REG != 0 && i == 0) begin
                mem_d[i]  = '0;
                busy_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_d[p] = mem_q[rd_addr[p]];
            rd_busy_d[p] = busy_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (bus.clr_en && bus.clr_addr == rd_addr[p]) begin
                rd_data_d[p] = '0;
                rd_busy_d[p] = 1'b0;
            end else if (bus.wr_en && bus.wr_addr == rd_addr[p]) begin
                rd_data_d[p] = bus.wr_data;
                rd_busy_d[p] = bus.rsv_en && (bus.rsv_addr == rd_addr[p]);
            end
`endif
            if (ZERO_REG != 0 && rd_addr[p] == '0) begin
                rd_data_d[p] = '0;
                rd_busy_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rstAll) begin
        if (rstAll) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q       <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_busy_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
            if (!bus.rd_stall) begin
                rd_data_q[0] <= rd_data_d[0];
                rd_data_q[1] <= rd_data_d[1];
                rd_busy_q    <= rd_busy_d;
            end
        end
    end

    assign bus.rd_data_a = rd_data_q[0];
    assign bus.rd_data_b = rd_data_q[1];
    assign bus.rd_busy_a = rd_busy_q[0];
    assign bus.rd_busy_b = rd_busy_q[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (ZERO_REG=0 and ZERO_REG=1) share one stimulus stream.
module tb_regfile_sb;
    logic clk;
    logic rstAll;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .rstAll(rstAll), .bus(bus0)
    );
    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rstAll(rstAll), .bus(bus1)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ba;
        logic        bb;
    } out_t;
    typedef struct packed {
        out_t z1;
        out_t z0;
    } pair_t;

    pair_t       sb_q[$];
    logic [15:0] m    [2][8];
    logic        bsy  [2][8];
    out_t        cur  [2];
    int          total = 0;
    int          bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) begin
                m[k][r]   = 16'h0;
                bsy[k][r] = 1'b0;
            end
            cur[k] = '0;
        end
    endtask

    // What a read port captures at the coming edge, given this cycle's operations.
    function automatic logic [16:0] peek(input int k, input logic [2:0] addr,
                                         input logic clr, input logic [2:0] ca,
                                         input logic wr, input logic [2:0] wa,
                                         input logic [15:0] wd,
                                         input logic rsv, input logic [2:0] ra);
        if (k == 1 && addr == 3'd0) return 17'h0;
`ifdef REGFILE_BYPASS_EN
        if (clr && ca == addr) return 17'h0;
        if (wr && wa == addr) return {wd, rsv && (ra == addr)};
`endif
        return {m[k][addr], bsy[k][addr]};
    endfunction

    task automatic model_step(input logic clr, input logic [2:0] ca,
                              input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                              input logic rsv, input logic [2:0] ra,
                              input logic st, input logic [2:0] aa, input logic [2:0] ab);
        pair_t       p;
        logic [16:0] v;
        for (int k = 0; k < 2; k++) begin
            if (!st) begin
                v = peek(k, aa, clr, ca, wr, wa, wd, rsv, ra);
                cur[k].a  = v[16:1];
                cur[k].ba = v[0];
                v = peek(k, ab, clr, ca, wr, wa, wd, rsv, ra);
                cur[k].b  = v[16:1];
                cur[k].bb = v[0];
            end
            // Apply lowest priority first so higher-priority operations overwrite.
            if (wr) begin
                m[k][wa]   = wd;
                bsy[k][wa] = 1'b0;
            end
            if (rsv) bsy[k][ra] = 1'b1;
            if (clr) begin
                m[k][ca]   = 16'h0;
                bsy[k][ca] = 1'b0;
            end
            if (k == 1) begin
                m[1][0]   = 16'h0;
                bsy[1][0] = 1'b0;
            end
        end
        p.z0 = cur[0];
        p.z1 = cur[1];
        sb_q.push_back(p);
    endtask

    task automatic drive(input logic clr, input logic [2:0] ca,
                         input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                         input logic rsv, input logic [2:0] ra,
                         input logic st, input logic [2:0] aa, input logic [2:0] ab);
        bus0.clr_en = clr;  bus0.clr_addr = ca;
        bus0.wr_en  = wr;   bus0.wr_addr  = wa;  bus0.wr_data = wd;
        bus0.rsv_en = rsv;  bus0.rsv_addr = ra;
        bus0.rd_stall = st; bus0.rd_addr_a = aa; bus0.rd_addr_b = ab;
        bus1.clr_en = clr;  bus1.clr_addr = ca;
        bus1.wr_en  = wr;   bus1.wr_addr  = wa;  bus1.wr_data = wd;
        bus1.rsv_en = rsv;  bus1.rsv_addr = ra;
        bus1.rd_stall = st; bus1.rd_addr_a = aa; bus1.rd_addr_b = ab;
    endtask

    task automatic cyc(input logic clr, input logic [2:0] ca,
                       input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                       input logic rsv, input logic [2:0] ra,
                       input logic st, input logic [2:0] aa, input logic [2:0] ab);
        @(negedge clk);
        drive(clr, ca, wr, wa, wd, rsv, ra, st, aa, ab);
        model_step(clr, ca, wr, wa, wd, rsv, ra, st, aa, ab);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_a0"}, bus0.rd_data_a, 16'h0);
        chk({tag, "_b0"}, bus0.rd_data_b, 16'h0);
        chk({tag, "_ba0"}, {15'h0, bus0.rd_busy_a}, 16'h0);
        chk({tag, "_bb0"}, {15'h0, bus0.rd_busy_b}, 16'h0);
        chk({tag, "_a1"}, bus1.rd_data_a, 16'h0);
        chk({tag, "_b1"}, bus1.rd_data_b, 16'h0);
        chk({tag, "_ba1"}, {15'h0, bus1.rd_busy_a}, 16'h0);
        chk({tag, "_bb1"}, {15'h0, bus1.rd_busy_b}, 16'h0);
    endtask

    // Reset pulse placed between edges while a write and reserve are being driven.
    task automatic reset_pulse();
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b1, 3'd1, 16'hDEAD, 1'b1, 3'd2, 1'b1, 3'd3, 3'd1);
        #2 rstAll = 1'b1;
        #1 chk_zero_outputs("rst_async");
        model_clear();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd1);
        #1 rstAll = 1'b0;
        model_step(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd1);
    endtask

    initial begin : monitor
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                chk("rd_data_a0", bus0.rd_data_a, p.z0.a);
                chk("rd_data_b0", bus0.rd_data_b, p.z0.b);
                chk("rd_busy_a0", {15'h0, bus0.rd_busy_a}, {15'h0, p.z0.ba});
                chk("rd_busy_b0", {15'h0, bus0.rd_busy_b}, {15'h0, p.z0.bb});
                chk("rd_data_a1", bus1.rd_data_a, p.z1.a);
                chk("rd_data_b1", bus1.rd_data_b, p.z1.b);
                chk("rd_busy_a1", {15'h0, bus1.rd_busy_a}, {15'h0, p.z1.ba});
                chk("rd_busy_b1", {15'h0, bus1.rd_busy_b}, {15'h0, p.z1.bb});
            end
        end
    end

    initial begin : stim
        int wait_cnt;
        rstAll = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        model_clear();
        #1 chk_zero_outputs("reset_state");
        repeat (2) @(negedge clk);
        rstAll = 1'b0;

        // Load r1..r7, reserve r3, then reset and read back.
        for (int r = 1; r < 8; r++) begin
            cyc(1'b0, 3'd0, 1'b1, 3'(r), 16'(r * 16'h1111), 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        end
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd3, 3'd7);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd7);
        reset_pulse();
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd7, 3'd5);

        // Write then read.
        cyc(1'b0, 3'd0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0);

        // Same-cycle write and read on both ports.
        cyc(1'b0, 3'd0, 1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);

        // Scoreboard sequence on r4.
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);
        cyc(1'b0, 3'd0, 1'b1, 3'd4, 16'h0077, 1'b1, 3'd4, 1'b0, 3'd4, 3'd0);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0);
        cyc(1'b0, 3'd0, 1'b1, 3'd4, 16'h00AA, 1'b0, 3'd0, 1'b0, 3'd0, 3'd4);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);

        // Clear beats write.
        cyc(1'b0, 3'd0, 1'b1, 3'd6, 16'h5555, 1'b1, 3'd6, 1'b0, 3'd0, 3'd0);
        cyc(1'b1, 3'd6, 1'b1, 3'd6, 16'h9999, 1'b0, 3'd0, 1'b0, 3'd6, 3'd6);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd6, 3'd6);

        // Stall while addresses and contents change.
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd4);
        cyc(1'b0, 3'd0, 1'b1, 3'd5, 16'hC0DE, 1'b0, 3'd0, 1'b1, 3'd1, 3'd2);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b1, 3'd3, 3'd6);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd7, 3'd0);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd4);

        // Register 0: real register in dut0, hard zero in dut1.
        cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)));
        end
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd1, 3'd2);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain actual=%0d pending required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the decode stage, successor to the 8x16 file. It provides one write port, two registered read ports with optional write-through bypass, and a per-register busy scoreboard that decode uses to detect RAW hazards against in-flight producers. Writeback drives the write port, decode drives the read, reserve and stall inputs, and the hazard unit consumes the busy flags.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1 register 0 reads as 0, ignores writes and is never busy

- clk  in  1  clock, all state updates on posedge
- rstAll  in  1  reset, asynchronous, active-high; clears every register, busy bit and output
- clr_en  in  1  synchronous clear of register clr_addr to 0 and of its busy bit
- clr_addr  in  ADDR_W  register to clear
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve: mark rsv_addr busy (producer issued)
- rsv_addr  in  ADDR_W  register to reserve
- rd_stall  in  1  when 1, read outputs hold their value
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  DATA_W  registered read data
- rd_busy_a, rd_busy_b  out  1  registered busy flag of the addressed register

## Operation
- State: DEPTH x DATA_W data array and a DEPTH-bit busy vector.
- Per-register update priority each posedge: rstAll > clr_en > rsv_en > wr_en.
  - Data: clr_en on the address writes 0. Otherwise wr_en writes wr_data.
  - Busy: clr_en on the address gives 0. Otherwise rsv_en on the address gives 1. Otherwise wr_en on the address gives 0. Otherwise the bit holds.
- Operations on different addresses in the same cycle all take effect.
- When rsv_en and wr_en target the same address, the data is written and the busy bit ends at 1, because the newer producer wins.
- ZERO_REG=1: writes, clears and reserves to address 0 are discarded; reads of address 0 return 0 with busy=0.
- Reads: on posedge with rd_stall=0, each port captures the addressed data and busy bit. With rd_stall=1, outputs are unchanged.
- No wrap-around or overflow conditions exist. Out-of-range addresses are impossible by construction (DEPTH = 2**ADDR_W).

## Timing
- Write, clear and reserve are visible in the array after the same posedge.
- Read latency is 1 cycle: the address is presented in cycle N and data and busy are valid after posedge N.
- Same-cycle read and write to one address: see Configuration.
- rstAll is asynchronous. On assertion:
  - all registers = 0, busy = 0;
  - rd_data_a = rd_data_b = 0, rd_busy_a = rd_busy_b = 0.
  - It overrides all other inputs, including mid-write and mid-stall.
- On the first posedge after rstAll deasserts, normal operation resumes. The array contents are not re-initialised.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose address matches wr_addr with wr_en=1 in the same cycle captures wr_data. It also captures the busy value as post-update, so a write clears busy unless a same-cycle rsv_en or clr_en overrides it. A same-cycle clr_en on the read address returns 0.
- REGFILE_BYPASS_EN undefined: read ports capture the pre-update array and busy values, giving old data for one cycle.

## Test plan
- Reset: load regs 1..7 with 0x1111..0x7777, reserve r3, pulse rstAll between edges -> all outputs 0 immediately; reading any register next returns 0 with busy 0.
- Write/read: write r5=0xBEEF, read r5 on port A the next cycle -> rd_data_a=0xBEEF one cycle later, rd_busy_a=0.
- Bypass: write r2=0x1234 while reading r2 on both ports in the same cycle.
  - With REGFILE_BYPASS_EN: both ports return 0x1234.
  - Without it: both ports return the old value 0x0000.
- Scoreboard: rsv r4, then read r4 -> busy 1. Then a same-cycle wr r4 and rsv r4 -> busy stays 1. Then a wr r4=0x00AA -> busy 0, data 0x00AA.
- Clear priority: r6=0x5555; in the same cycle assert clr r6 and wr r6=0x9999 -> r6=0, busy 0.
- Stall and zero register (ZERO_REG=1): hold rd_stall=1 for 3 cycles while changing addresses -> outputs frozen. Write r0=0xFFFF and reserve r0 -> r0 reads 0 with busy 0.
